// File: rtl/conv_1g_tx_serializer.sv
// ============================================================================
// conv_1g_tx_serializer
//
// Transmit-side 1G converter. Reads 64-bit packet words (sop/eop/mod) from a
// showahead packet FIFO and serializes them, one byte per enabled MAC clock,
// onto the GMII MAC transmit control path. At 100M/10M the MAC clock enable
// is asserted 1-in-10 / 1-in-100 and every byte is held between enables.
//
// The FIFO pops the head word on the same edge that pkt_rd_req_o is high, so
// the pop request is decoded combinationally from the current head fields.
//
// Ports:
//   clk_mac_i      in   MAC clock (only clock)
//   rst_n_i        in   asynchronous active-low reset
//   clk_mac_en_i   in   MAC clock enable (rate adaptation)
//   pkt_data_i     in   FIFO head word, byte 0 = [7:0] goes out first
//   pkt_sop_i      in   head word starts a frame
//   pkt_eop_i      in   head word ends a frame
//   pkt_mod_i      in   valid bytes in an eop word (0 = all 8)
//   pkt_avail_i    in   FIFO not empty, head fields valid
//   pkt_rd_req_o   out  pop head word (one clk, only on enabled cycles)
//   tx_ready_i     in   MAC can accept a new frame start
//   tx_data_o      out  byte to the MAC
//   tx_data_en_o   out  tx_data_o valid
//   tx_data_end_o  out  last byte of the frame
//   tx_err_o       out  frame aborted (only together with tx_data_end_o)
//   underrun_o     out  one-clk pulse per underrun / missing-eop abort
// ============================================================================
module conv_1g_tx_serializer #(
    parameter int IDLE_GAP          = 0,
    parameter bit ABORT_ON_UNDERRUN = 1'b1
) (
    input  logic        clk_mac_i,
    input  logic        rst_n_i,
    input  logic        clk_mac_en_i,
    input  logic [63:0] pkt_data_i,
    input  logic        pkt_sop_i,
    input  logic        pkt_eop_i,
    input  logic [2:0]  pkt_mod_i,
    input  logic        pkt_avail_i,
    output logic        pkt_rd_req_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_data_en_o,
    output logic        tx_data_end_o,
    output logic        tx_err_o,
    output logic        underrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ERR,
        S_DROP,
        S_GAP
    } state_t;

    // Gap counter counts the extra idle enables beyond the mandatory one.
    localparam int              GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP);

    state_t            state_q,    state_d;
    logic [63:0]       word_q,     word_d;
    logic [2:0]        idx_q,      idx_d;
    logic              eop_q,      eop_d;
    logic [2:0]        mod_q,      mod_d;
    logic              drop_q,     drop_d;
    logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
    logic [7:0]        tx_data_q,  tx_data_d;
    logic              tx_en_q,    tx_en_d;
    logic              tx_end_q,   tx_end_d;
    logic              tx_err_q,   tx_err_d;
    logic              underrun_q, underrun_d;
    logic              rd_req_c;

    logic [7:0]        cur_byte;
    logic [2:0]        last_idx;
    logic              at_last;

    assign cur_byte = word_q[{idx_q, 3'b000} +: 8];
    // An eop word with mod=N ends at byte N-1; every other word ends at byte 7.
    assign last_idx = (eop_q && (mod_q != 3'd0)) ? (mod_q - 3'd1) : 3'd7;
    assign at_last  = (idx_q == last_idx);

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        eop_d      = eop_q;
        mod_d      = mod_q;
        drop_d     = drop_q;
        gap_cnt_d  = gap_cnt_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = tx_en_q;
        tx_end_d   = tx_end_q;
        tx_err_d   = tx_err_q;
        underrun_d = 1'b0;          // one MAC clock wide regardless of rate
        rd_req_c   = 1'b0;

        if (clk_mac_en_i) begin
            tx_data_d = 8'h00;
            tx_en_d   = 1'b0;
            tx_end_d  = 1'b0;
            tx_err_d  = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pkt_avail_i) begin
                        if (!pkt_sop_i) begin
                            // Orphan word outside a frame: discard it.
                            rd_req_c = 1'b1;
                        end else if (tx_ready_i) begin
                            rd_req_c  = 1'b1;
                            word_d    = pkt_data_i;
                            eop_d     = pkt_eop_i;
                            mod_d     = pkt_mod_i;
                            tx_data_d = pkt_data_i[7:0];
                            tx_en_d   = 1'b1;
                            idx_d     = 3'd1;
                            if (pkt_eop_i && (pkt_mod_i == 3'd1)) begin
                                // One-byte frame: byte 0 is already the end.
                                tx_end_d  = 1'b1;
                                gap_cnt_d = GAP_LOAD;
                                state_d   = S_GAP;
                            end else begin
                                state_d = S_SEND;
                            end
                        end
                    end
                end

                S_SEND: begin
                    tx_data_d = cur_byte;
                    tx_en_d   = 1'b1;
                    idx_d     = idx_q + 3'd1;
                    if (at_last) begin
                        if (eop_q) begin
                            tx_end_d  = 1'b1;
                            gap_cnt_d = GAP_LOAD;
                            state_d   = S_GAP;
                        end else if (!pkt_avail_i) begin
                            drop_d  = ABORT_ON_UNDERRUN;
                            state_d = S_ERR;
                        end else if (pkt_sop_i) begin
                            // Missing eop: keep the new sop word for later.
                            drop_d  = 1'b0;
                            state_d = S_ERR;
                        end else begin
                            // Load the continuation word on this edge so the
                            // next enable sends its byte 0 without a bubble.
                            rd_req_c = 1'b1;
                            word_d   = pkt_data_i;
                            eop_d    = pkt_eop_i;
                            mod_d    = pkt_mod_i;
                            idx_d    = 3'd0;
                        end
                    end
                end

                S_ERR: begin
                    tx_data_d  = 8'h00;
                    tx_en_d    = 1'b1;
                    tx_end_d   = 1'b1;
                    tx_err_d   = 1'b1;
                    underrun_d = 1'b1;
                    if (drop_q) begin
                        state_d = S_DROP;
                    end else begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end
                end

                S_DROP: begin
                    if (pkt_avail_i) begin
                        if (pkt_sop_i) begin
                            // Next frame already waiting: stop discarding.
                            gap_cnt_d = GAP_LOAD;
                            state_d   = S_GAP;
                        end else begin
                            rd_req_c = 1'b1;
                            if (pkt_eop_i) begin
                                gap_cnt_d = GAP_LOAD;
                                state_d   = S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_mac_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            eop_q      <= 1'b0;
            mod_q      <= '0;
            drop_q     <= 1'b0;
            gap_cnt_q  <= '0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            tx_end_q   <= 1'b0;
            tx_err_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            eop_q      <= eop_d;
            mod_q      <= mod_d;
            drop_q     <= drop_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            tx_end_q   <= tx_end_d;
            tx_err_q   <= tx_err_d;
            underrun_q <= underrun_d;
        end
    end

    // No pops while reset is held, so leftover words stay for IDLE to clean up.
    assign pkt_rd_req_o  = rd_req_c & rst_n_i;
    assign tx_data_o     = tx_data_q;
    assign tx_data_en_o  = tx_en_q;
    assign tx_data_end_o = tx_end_q;
    assign tx_err_o      = tx_err_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_conv_1g_tx_serializer.sv
// ============================================================================
// tb_conv_1g_tx_serializer
//
// Directed bench for conv_1g_tx_serializer. A small array FIFO models the
// showahead packet FIFO (head advances on pkt_rd_req_o), a divider produces
// clk_mac_en_i, and a negedge monitor logs every freshly registered byte.
// Each scenario task pushes words, runs the clock and compares the log with
// hand-computed values.
// ============================================================================
module tb_conv_1g_tx_serializer;

    localparam int IDLE_GAP = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en;
    logic [63:0] pkt_data;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [2:0]  pkt_mod;
    logic        pkt_avail;
    logic        pkt_rd_req;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_end;
    logic        tx_err;
    logic        underrun;

    // FIFO model
    logic [63:0] mem_data [256];
    logic        mem_sop  [256];
    logic        mem_eop  [256];
    logic [2:0]  mem_mod  [256];
    logic [7:0]  head = 8'd0;
    logic [7:0]  tail = 8'd0;

    int en_div = 1;
    int en_cnt = 0;

    // Monitor state
    logic [7:0] lg_data [512];
    logic       lg_end  [512];
    logic       lg_err  [512];
    int         lg_cyc  [512];
    int         n_bytes   = 0;
    int         cyc       = 0;
    int         rd_count  = 0;
    int         rd_double = 0;
    int         ur_count  = 0;
    int         en_cycles = 0;
    logic       en_edge   = 1'b0;
    logic       rd_prev   = 1'b0;

    int total = 0;
    int bad   = 0;

    assign pkt_data  = mem_data[head];
    assign pkt_sop   = mem_sop[head];
    assign pkt_eop   = mem_eop[head];
    assign pkt_mod   = mem_mod[head];
    assign pkt_avail = (head != tail);
    assign clk_en    = (en_cnt == 0);

    conv_1g_tx_serializer #(
        .IDLE_GAP          (IDLE_GAP),
        .ABORT_ON_UNDERRUN (1'b1)
    ) dut (
        .clk_mac_i     (clk),
        .rst_n_i       (rst_n),
        .clk_mac_en_i  (clk_en),
        .pkt_data_i    (pkt_data),
        .pkt_sop_i     (pkt_sop),
        .pkt_eop_i     (pkt_eop),
        .pkt_mod_i     (pkt_mod),
        .pkt_avail_i   (pkt_avail),
        .pkt_rd_req_o  (pkt_rd_req),
        .tx_ready_i    (tx_ready),
        .tx_data_o     (tx_data),
        .tx_data_en_o  (tx_en),
        .tx_data_end_o (tx_end),
        .tx_err_o      (tx_err),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_cnt  <= (en_cnt + 1 >= en_div) ? 0 : en_cnt + 1;
        en_edge <= clk_en;
        rd_prev <= pkt_rd_req;
        if (pkt_rd_req) begin
            head     <= head + 8'd1;
            rd_count <= rd_count + 1;
            if (rd_prev && en_div > 1) rd_double <= rd_double + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && tx_en) en_cycles <= en_cycles + 1;
        if (underrun) ur_count <= ur_count + 1;
        if (rst_n && en_edge && tx_en && n_bytes < 512) begin
            lg_data[n_bytes] <= tx_data;
            lg_end[n_bytes]  <= tx_end;
            lg_err[n_bytes]  <= tx_err;
            lg_cyc[n_bytes]  <= cyc;
            n_bytes          <= n_bytes + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
        mem_data[tail] = d;
        mem_sop[tail]  = s;
        mem_eop[tail]  = e;
        mem_mod[tail]  = m;
        tail = tail + 8'd1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        run(3);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", tx_en); end
        total++; if (tx_end !== 1'b0) begin bad++; $display("FAIL reset_end got=%b exp=0", tx_end); end
        total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", tx_err); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        // An orphan word present during reset must not be popped yet.
        push(64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 1'b0, 3'd0);
        run(2);
        total++; if (pkt_rd_req !== 1'b0) begin bad++; $display("FAIL reset_rdreq got=%b exp=0", pkt_rd_req); end
        total++; if (head === tail) begin bad++; $display("FAIL reset_nopop head=%0d exp!=%0d", head, tail); end
        rst_n = 1'b1;
        run(5);
        total++; if (head !== tail) begin bad++; $display("FAIL orphan_after_reset head=%0d exp=%0d", head, tail); end
        total++; if (n_bytes !== 0) begin bad++; $display("FAIL orphan_no_output bytes=%0d exp=0", n_bytes); end
    endtask

    task automatic test_long_frame();
        int b0 = n_bytes;
        int r0 = rd_count;
        int gap;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] kb = 8'(k);
            push({8{kb}}, k == 0, k == 7, 3'd0);
        end
        push(64'h0000_0000_0000_5150, 1'b1, 1'b1, 3'd2);
        run(120);
        total++; if (n_bytes - b0 !== 66) begin bad++; $display("FAIL long_count got=%0d exp=66", n_bytes - b0); end
        for (int i = 0; i < 64; i++) begin
            total++; if (lg_data[b0+i] !== 8'(i / 8)) begin bad++; $display("FAIL long_byte%0d got=%h exp=%h", i, lg_data[b0+i], 8'(i / 8)); end
            total++; if (lg_end[b0+i] !== (i == 63)) begin bad++; $display("FAIL long_end%0d got=%b exp=%b", i, lg_end[b0+i], i == 63); end
            if (i > 0) begin
                total++; if (lg_cyc[b0+i] - lg_cyc[b0+i-1] !== 1) begin bad++; $display("FAIL long_contig%0d gap=%0d exp=1", i, lg_cyc[b0+i] - lg_cyc[b0+i-1]); end
            end
        end
        total++; if (lg_err[b0+63] !== 1'b0) begin bad++; $display("FAIL long_err got=%b exp=0", lg_err[b0+63]); end
        total++; if (rd_count - r0 !== 9) begin bad++; $display("FAIL long_rdreq got=%0d exp=9", rd_count - r0); end
        gap = lg_cyc[b0+64] - lg_cyc[b0+63];
        total++; if (gap < 2 + IDLE_GAP) begin bad++; $display("FAIL long_ifg got=%0d exp>=%0d", gap, 2 + IDLE_GAP); end
        total++; if (lg_data[b0+64] !== 8'h50 || lg_data[b0+65] !== 8'h51) begin bad++; $display("FAIL next_bytes got=%h,%h exp=50,51", lg_data[b0+64], lg_data[b0+65]); end
        total++; if (lg_end[b0+64] !== 1'b0 || lg_end[b0+65] !== 1'b1) begin bad++; $display("FAIL next_end got=%b%b exp=01", lg_end[b0+64], lg_end[b0+65]); end
    endtask

    task automatic test_single_word();
        int b0 = n_bytes;
        int r0 = rd_count;
        push(64'hFFFF_FFFF_FF03_0201, 1'b1, 1'b1, 3'd3);
        run(20);
        total++; if (n_bytes - b0 !== 3) begin bad++; $display("FAIL mod3_count got=%0d exp=3", n_bytes - b0); end
        for (int i = 0; i < 3; i++) begin
            total++; if (lg_data[b0+i] !== 8'(i + 1)) begin bad++; $display("FAIL mod3_byte%0d got=%h exp=%h", i, lg_data[b0+i], 8'(i + 1)); end
            total++; if (lg_end[b0+i] !== (i == 2)) begin bad++; $display("FAIL mod3_end%0d got=%b exp=%b", i, lg_end[b0+i], i == 2); end
        end
        push(64'h1111_2222_3333_44A5, 1'b1, 1'b1, 3'd1);
        run(20);
        total++; if (n_bytes - b0 !== 4) begin bad++; $display("FAIL mod1_count got=%0d exp=4", n_bytes - b0); end
        total++; if (lg_data[b0+3] !== 8'hA5) begin bad++; $display("FAIL mod1_byte got=%h exp=a5", lg_data[b0+3]); end
        total++; if (lg_end[b0+3] !== 1'b1 || lg_err[b0+3] !== 1'b0) begin bad++; $display("FAIL mod1_flags end/err got=%b/%b exp=1/0", lg_end[b0+3], lg_err[b0+3]); end
        total++; if (rd_count - r0 !== 2) begin bad++; $display("FAIL single_rdreq got=%0d exp=2", rd_count - r0); end
    endtask

    task automatic test_underrun();
        int b0 = n_bytes;
        int r0 = rd_count;
        int u0 = ur_count;
        push({8{8'h10}}, 1'b1, 1'b0, 3'd0);
        run(20);
        total++; if (n_bytes - b0 !== 9) begin bad++; $display("FAIL ur_count got=%0d exp=9", n_bytes - b0); end
        for (int i = 0; i < 8; i++) begin
            total++; if (lg_data[b0+i] !== 8'h10 || lg_end[b0+i] !== 1'b0) begin bad++; $display("FAIL ur_byte%0d got=%h end=%b exp=10 end=0", i, lg_data[b0+i], lg_end[b0+i]); end
        end
        total++; if (lg_data[b0+8] !== 8'h00 || lg_end[b0+8] !== 1'b1 || lg_err[b0+8] !== 1'b1) begin bad++; $display("FAIL ur_errbyte got=%h end=%b err=%b exp=00 1 1", lg_data[b0+8], lg_end[b0+8], lg_err[b0+8]); end
        total++; if (ur_count - u0 !== 1) begin bad++; $display("FAIL ur_pulse got=%0d exp=1", ur_count - u0); end
        push({8{8'h11}}, 1'b0, 1'b0, 3'd0);
        push({8{8'h12}}, 1'b0, 1'b1, 3'd0);
        run(10);
        total++; if (n_bytes - b0 !== 9) begin bad++; $display("FAIL ur_drop_silent got=%0d exp=9", n_bytes - b0); end
        total++; if (head !== tail) begin bad++; $display("FAIL ur_drop_pop head=%0d exp=%0d", head, tail); end
        push(64'h0000_0000_2423_2221, 1'b1, 1'b1, 3'd4);
        run(20);
        total++; if (n_bytes - b0 !== 13) begin bad++; $display("FAIL ur_next_count got=%0d exp=13", n_bytes - b0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (lg_data[b0+9+i] !== 8'(8'h21 + i)) begin bad++; $display("FAIL ur_next_byte%0d got=%h exp=%h", i, lg_data[b0+9+i], 8'(8'h21 + i)); end
        end
        total++; if (lg_end[b0+12] !== 1'b1 || lg_err[b0+12] !== 1'b0) begin bad++; $display("FAIL ur_next_end end/err got=%b/%b exp=1/0", lg_end[b0+12], lg_err[b0+12]); end
        total++; if (rd_count - r0 !== 4) begin bad++; $display("FAIL ur_rdreq got=%0d exp=4", rd_count - r0); end
        total++; if (ur_count - u0 !== 1) begin bad++; $display("FAIL ur_pulse_total got=%0d exp=1", ur_count - u0); end
    endtask

    task automatic test_slow_rate();
        int b0, r0, d0, c0;
        @(negedge clk);
        en_div = 10;
        run(12);
        b0 = n_bytes; r0 = rd_count; d0 = rd_double; c0 = en_cycles;
        push(64'h3736_3534_3332_3130, 1'b1, 1'b0, 3'd0);
        push(64'h3F3E_3D3C_3B3A_3938, 1'b0, 1'b1, 3'd0);
        run(220);
        total++; if (n_bytes - b0 !== 16) begin bad++; $display("FAIL slow_count got=%0d exp=16", n_bytes - b0); end
        for (int i = 0; i < 16; i++) begin
            total++; if (lg_data[b0+i] !== 8'(8'h30 + i)) begin bad++; $display("FAIL slow_byte%0d got=%h exp=%h", i, lg_data[b0+i], 8'(8'h30 + i)); end
            if (i > 0) begin
                total++; if (lg_cyc[b0+i] - lg_cyc[b0+i-1] !== 10) begin bad++; $display("FAIL slow_hold%0d got=%0d exp=10", i, lg_cyc[b0+i] - lg_cyc[b0+i-1]); end
            end
        end
        total++; if (lg_end[b0+15] !== 1'b1 || lg_end[b0+14] !== 1'b0) begin bad++; $display("FAIL slow_end got=%b%b exp=01", lg_end[b0+14], lg_end[b0+15]); end
        total++; if (en_cycles - c0 !== 160) begin bad++; $display("FAIL slow_en_clks got=%0d exp=160", en_cycles - c0); end
        total++; if (rd_count - r0 !== 2) begin bad++; $display("FAIL slow_rdreq got=%0d exp=2", rd_count - r0); end
        total++; if (rd_double - d0 !== 0) begin bad++; $display("FAIL slow_rdreq_width got=%0d exp=0", rd_double - d0); end
        @(negedge clk);
        en_div = 1;
        run(15);
    endtask

    task automatic test_orphan_missing_eop();
        int b0 = n_bytes;
        int r0 = rd_count;
        int u0 = ur_count;
        push(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 3'd0);
        push({8{8'h41}}, 1'b1, 1'b0, 3'd0);
        push({8{8'h42}}, 1'b0, 1'b0, 3'd0);
        push({8{8'h51}}, 1'b1, 1'b0, 3'd0);
        push({8{8'h52}}, 1'b0, 1'b1, 3'd3);
        run(80);
        total++; if (n_bytes - b0 !== 28) begin bad++; $display("FAIL meop_count got=%0d exp=28", n_bytes - b0); end
        for (int i = 0; i < 28; i++) begin
            logic [7:0] exp_b;
            if (i < 8)       exp_b = 8'h41;
            else if (i < 16) exp_b = 8'h42;
            else if (i == 16) exp_b = 8'h00;
            else if (i < 25) exp_b = 8'h51;
            else             exp_b = 8'h52;
            total++; if (lg_data[b0+i] !== exp_b) begin bad++; $display("FAIL meop_byte%0d got=%h exp=%h", i, lg_data[b0+i], exp_b); end
            total++; if (lg_end[b0+i] !== (i == 16 || i == 27) || lg_err[b0+i] !== (i == 16)) begin bad++; $display("FAIL meop_flags%0d end/err got=%b/%b", i, lg_end[b0+i], lg_err[b0+i]); end
        end
        total++; if (lg_cyc[b0+17] - lg_cyc[b0+16] < 2 + IDLE_GAP) begin bad++; $display("FAIL meop_ifg got=%0d exp>=%0d", lg_cyc[b0+17] - lg_cyc[b0+16], 2 + IDLE_GAP); end
        total++; if (rd_count - r0 !== 5) begin bad++; $display("FAIL meop_rdreq got=%0d exp=5", rd_count - r0); end
        total++; if (ur_count - u0 !== 1) begin bad++; $display("FAIL meop_underrun got=%0d exp=1", ur_count - u0); end
    endtask

    task automatic test_reset_mid_frame();
        int b0 = n_bytes;
        int r0 = rd_count;
        push({8{8'h61}}, 1'b1, 1'b0, 3'd0);
        push({8{8'h62}}, 1'b0, 1'b0, 3'd0);
        push({8{8'h63}}, 1'b0, 1'b1, 3'd0);
        for (int t = 0; t < 60; t++) begin
            run(1);
            if (n_bytes - b0 >= 5) break;
        end
        total++; if (n_bytes - b0 !== 5) begin bad++; $display("FAIL rst_mid_reach got=%0d exp=5", n_bytes - b0); end
        rst_n = 1'b0;
        #1;
        total++; if (tx_en !== 1'b0 || tx_end !== 1'b0 || tx_err !== 1'b0) begin bad++; $display("FAIL rst_mid_flags en/end/err got=%b%b%b exp=000", tx_en, tx_end, tx_err); end
        total++; if (tx_data !== 8'h00 || underrun !== 1'b0 || pkt_rd_req !== 1'b0) begin bad++; $display("FAIL rst_mid_outs data=%h ur=%b rd=%b exp=00 0 0", tx_data, underrun, pkt_rd_req); end
        run(3);
        rst_n = 1'b1;
        run(10);
        total++; if (n_bytes - b0 !== 5) begin bad++; $display("FAIL rst_mid_leftover got=%0d exp=5", n_bytes - b0); end
        total++; if (head !== tail) begin bad++; $display("FAIL rst_mid_drain head=%0d exp=%0d", head, tail); end
        push(64'h0000_0075_7473_7271, 1'b1, 1'b1, 3'd5);
        run(20);
        total++; if (n_bytes - b0 !== 10) begin bad++; $display("FAIL rst_mid_next_count got=%0d exp=10", n_bytes - b0); end
        for (int i = 0; i < 5; i++) begin
            total++; if (lg_data[b0+i] !== 8'h61) begin bad++; $display("FAIL rst_mid_pre%0d got=%h exp=61", i, lg_data[b0+i]); end
            total++; if (lg_data[b0+5+i] !== 8'(8'h71 + i) || lg_end[b0+5+i] !== (i == 4)) begin bad++; $display("FAIL rst_mid_post%0d got=%h end=%b exp=%h end=%b", i, lg_data[b0+5+i], lg_end[b0+5+i], 8'(8'h71 + i), i == 4); end
        end
        total++; if (rd_count - r0 !== 4) begin bad++; $display("FAIL rst_mid_rdreq got=%0d exp=4", rd_count - r0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_data[i] = '0;
            mem_sop[i]  = 1'b0;
            mem_eop[i]  = 1'b0;
            mem_mod[i]  = 3'd0;
        end
        test_reset();
        test_long_frame();
        test_single_word();
        test_underrun();
        test_slow_rate();
        test_orphan_missing_eop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
